// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic mips32 pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB).
// Valid/ready handshake with a synchronous flush. When the stage holds no valid
// instruction the control field reads CTRL_BUBBLE, so downstream stages see a NOP.
//
// Build option: define PIPE_SKID_EN for a 2-entry skid buffer. This gives full
// throughput with a registered in_ready. Without it the stage is a single
// register whose in_ready is combinational. The port list is the same in both builds.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous kill of all stage contents
//   in_valid   upstream has an instruction
//   in_ready   stage accepts an instruction this cycle
//   in_ctrl    upstream control field   [CTRL_W]
//   in_data    upstream payload         [DATA_W]
//   out_valid  stage holds a valid instruction
//   out_ready  downstream accepts (0 = stall/hazard hold)
//   out_ctrl   control field, CTRL_BUBBLE when out_valid=0
//   out_data   payload, holds last loaded value when out_valid=0
//   occupancy  entries held (0..1 base, 0..2 with skid)
module pipe_stage_reg #(
  parameter int unsigned       DATA_W      = 160,
  parameter int unsigned       CTRL_W      = 16,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic accept;
  logic emit;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

`ifdef PIPE_SKID_EN

  // Entry count is the state: EMPTY=0, BUSY=1 (main only), FULL=2 (main + skid)
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_d;
  logic              valid_d;
  logic              ready_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [DATA_W-1:0] data_d;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [CTRL_W-1:0] skid_ctrl_d;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] skid_data_d;

  // State and data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_ctrl  <= CTRL_BUBBLE;
      out_data  <= '0;
      skid_ctrl <= CTRL_BUBBLE;
      skid_data <= '0;
    end else begin
      state     <= state_d;
      out_valid <= valid_d;
      in_ready  <= ready_d;
      out_ctrl  <= ctrl_d;
      out_data  <= data_d;
      skid_ctrl <= skid_ctrl_d;
      skid_data <= skid_data_d;
    end
  end

  // Next state and next register contents
  always_comb begin
    state_d     = state;
    ctrl_d      = out_ctrl;
    data_d      = out_data;
    skid_ctrl_d = skid_ctrl;
    skid_data_d = skid_data;
    if (flush) begin
      state_d = EMPTY;
      ctrl_d  = CTRL_BUBBLE;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_d = BUSY;
            ctrl_d  = in_ctrl;
            data_d  = in_data;
          end
        end
        BUSY: begin
          if (accept && emit) begin
            ctrl_d = in_ctrl;
            data_d = in_data;
          end else if (accept) begin
            // Downstream stalled: park the new beat behind the main entry
            state_d     = FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (emit) begin
            state_d = EMPTY;
            ctrl_d  = CTRL_BUBBLE;
          end
        end
        FULL: begin
          // in_ready is low here, so only the skid-to-main move can happen
          if (emit) begin
            state_d = BUSY;
            ctrl_d  = skid_ctrl;
            data_d  = skid_data;
          end
        end
        default: begin
          state_d = EMPTY;
          ctrl_d  = CTRL_BUBBLE;
        end
      endcase
    end
    valid_d = (state_d != EMPTY);
    ready_d = (state_d != FULL);
  end

  assign occupancy = 2'(state);

`else

  logic              valid_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [DATA_W-1:0] data_d;

  // Single entry: a slot frees up in the same cycle the held beat leaves
  assign in_ready = !out_valid || out_ready;

  // Main register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ctrl  <= CTRL_BUBBLE;
      out_data  <= '0;
    end else begin
      out_valid <= valid_d;
      out_ctrl  <= ctrl_d;
      out_data  <= data_d;
    end
  end

  // Next contents: flush, then load, then drain
  always_comb begin
    valid_d = out_valid;
    ctrl_d  = out_ctrl;
    data_d  = out_data;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_BUBBLE;
    end else if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = in_ctrl;
      data_d  = in_data;
    end else if (emit) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_BUBBLE;
    end
  end

  assign occupancy = {1'b0, out_valid};

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg. A queue-based reference model runs alongside
// directed scenarios and randomized traffic. Define PIPE_SKID_EN to match the
// skid build of the design.
module tb_pipe_stage_reg;
  localparam int unsigned DATA_W = 160;
  localparam int unsigned CTRL_W = 16;
  localparam logic [CTRL_W-1:0] BUB = '0;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_BUBBLE(BUB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of capacity 1 (base) or 2 (skid)
  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [DATA_W-1:0] d;
  } beat_t;

  beat_t             q[$];
  logic [DATA_W-1:0] m_last;
  bit                m_acc;

  function automatic bit m_in_ready();
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_last = '0;
    end else begin
      if (flush) begin
        q.delete();
      end else begin
        m_acc = in_valid && m_in_ready();
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (m_acc) q.push_back('{c: in_ctrl, d: in_data});
      end
      if (q.size() > 0) m_last = q[0].d;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("out_valid", DATA_W'(out_valid), DATA_W'(q.size() > 0));
      check("out_ctrl", DATA_W'(out_ctrl), DATA_W'((q.size() > 0) ? q[0].c : BUB));
      check("out_data", out_data, (q.size() > 0) ? q[0].d : m_last);
      check("in_ready", DATA_W'(in_ready), DATA_W'(m_in_ready()));
      check("occupancy", DATA_W'(occupancy), DATA_W'(q.size()));
    end
  end

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c,
                       input logic [DATA_W-1:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b1;
    #8;
    check("reset_valid", DATA_W'(out_valid), DATA_W'(1'b0));
    check("reset_ctrl", DATA_W'(out_ctrl), DATA_W'(BUB));
    check("reset_ready", DATA_W'(in_ready), DATA_W'(1'b1));
    check("reset_occ", DATA_W'(occupancy), DATA_W'(2'd0));
    check("reset_data", out_data, DATA_W'(0));
    #4 rst = 1'b0;
    chk_en = 1'b1;

    // Back-to-back stream 1..4
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, CTRL_W'(16 + k), DATA_W'(k), 1'b1, 1'b0);
      sample();
      if (k > 1) begin
        check("stream_data", out_data, DATA_W'(k - 1));
        check("stream_valid", DATA_W'(out_valid), DATA_W'(1'b1));
      end
    end
    drive(1'b0, '0, '0, 1'b1, 1'b0); sample();
    check("stream_last", out_data, DATA_W'(4));
    drive(1'b0, '0, '0, 1'b1, 1'b0); sample();
    check("stream_drained", DATA_W'(out_valid), DATA_W'(1'b0));

    // Stall hold, then a second beat behind it
    drive(1'b1, CTRL_W'(3), DATA_W'(8'hA5), 1'b0, 1'b0); sample();
    drive(1'b0, '0, '0, 1'b0, 1'b0); sample();
    check("stall_data1", out_data, DATA_W'(8'hA5));
    drive(1'b0, '0, '0, 1'b0, 1'b0); sample();
    check("stall_valid2", DATA_W'(out_valid), DATA_W'(1'b1));
    drive(1'b1, CTRL_W'(4), DATA_W'(8'hB6), 1'b0, 1'b0); sample();
    check("stall_data3", out_data, DATA_W'(8'hA5));
    drive(1'b0, '0, '0, 1'b0, 1'b0); sample();
    check("park_ready", DATA_W'(in_ready), DATA_W'(1'b0));
    check("park_occ", DATA_W'(occupancy), DATA_W'(SKID ? 2'd2 : 2'd1));
    drive(1'b0, '0, '0, 1'b1, 1'b0); sample();
    check("release_first", out_data, DATA_W'(8'hA5));
    drive(1'b0, '0, '0, 1'b1, 1'b0); sample();
    check("release_second_valid", DATA_W'(out_valid), DATA_W'(SKID));
    if (SKID) check("release_second_data", out_data, DATA_W'(8'hB6));
    drive(1'b0, '0, '0, 1'b1, 1'b0); sample();

    // Flush while full, then flush with an acceptable beat offered
    drive(1'b1, CTRL_W'(1), DATA_W'(8'h11), 1'b0, 1'b0); sample();
    drive(1'b1, CTRL_W'(2), DATA_W'(8'h22), 1'b0, 1'b0); sample();
    drive(1'b1, CTRL_W'(9), DATA_W'(8'h77), 1'b0, 1'b1); sample();
    drive(1'b0, '0, '0, 1'b1, 1'b0); sample();
    check("flush_valid", DATA_W'(out_valid), DATA_W'(1'b0));
    check("flush_ctrl", DATA_W'(out_ctrl), DATA_W'(BUB));
    check("flush_occ", DATA_W'(occupancy), DATA_W'(2'd0));
    check("flush_data_kept", out_data, DATA_W'(8'h11));
    drive(1'b1, CTRL_W'(9), DATA_W'(8'h77), 1'b1, 1'b1); sample();
    drive(1'b0, '0, '0, 1'b1, 1'b0); sample();
    check("flush_drop_valid", DATA_W'(out_valid), DATA_W'(1'b0));
    check("flush_drop_data", out_data, DATA_W'(8'h11));

    // Bubble propagation: in_valid 1,0,1
    drive(1'b1, CTRL_W'(5), DATA_W'(8'h51), 1'b1, 1'b0); sample();
    drive(1'b0, '0, '0, 1'b1, 1'b0); sample();
    check("gap_ctrl_a", DATA_W'(out_ctrl), DATA_W'(16'd5));
    drive(1'b1, CTRL_W'(7), DATA_W'(8'h53), 1'b1, 1'b0); sample();
    check("gap_valid", DATA_W'(out_valid), DATA_W'(1'b0));
    check("gap_ctrl", DATA_W'(out_ctrl), DATA_W'(BUB));
    drive(1'b0, '0, '0, 1'b1, 1'b0); sample();
    check("gap_ctrl_b", DATA_W'(out_ctrl), DATA_W'(16'd7));
    drive(1'b0, '0, '0, 1'b1, 1'b0); sample();

    // Asynchronous reset mid-stream
    drive(1'b1, CTRL_W'(6), DATA_W'(8'h99), 1'b0, 1'b0); sample();
    drive(1'b0, '0, '0, 1'b0, 1'b0); sample();
    check("pre_rst_valid", DATA_W'(out_valid), DATA_W'(1'b1));
    #2 rst = 1'b1;
    #1;
    check("rst_valid", DATA_W'(out_valid), DATA_W'(1'b0));
    check("rst_ctrl", DATA_W'(out_ctrl), DATA_W'(BUB));
    check("rst_ready", DATA_W'(in_ready), DATA_W'(1'b1));
    check("rst_occ", DATA_W'(occupancy), DATA_W'(2'd0));
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;

    // Randomized traffic with varying valid/ready pressure
    for (int i = 0; i < 10000; i++) begin
      int vb;
      int rb;
      vb = ((i / 1000) % 3) + 1;
      rb = ((i / 700) % 4) + 1;
      drive(1'b1 && ($urandom_range(3) < vb), CTRL_W'($urandom),
            {$urandom, $urandom, $urandom, $urandom, 32'(i)},
            ($urandom_range(3) < rb), ($urandom_range(127) == 0));
    end
    for (int i = 0; i < 4; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
    sample();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
